// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pkg
//  Description : Shared types and helpers for the radix-4 Booth multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Recoded radix-4 Booth digit
  typedef enum logic [2:0] {
    D_ZERO = 3'd0,
    D_PM   = 3'd1,
    D_P2M  = 3'd2,
    D_MM   = 3'd3,
    D_M2M  = 3'd4
  } digit_t;

  // Radix-4 iterations needed for a WIDTH-bit operand extended by two bits
  function automatic int booth_iter(input int width);
    return width / 2 + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_r4_enc.sv
`default_nettype none
// ============================================================================
//  Module      : booth_r4_enc
//  Description : Combinational radix-4 Booth recoder, {Q[1:0], q_m1} -> digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_r4_enc
  import booth_pkg::*;
(
  input  logic [2:0] win,
  output digit_t     digit
);

  // Map the three-bit multiplier window onto a signed digit in {-2..+2}
  always_comb begin
    digit = D_ZERO;
    case (win)
      3'b001, 3'b010: digit = D_PM;
      3'b011:         digit = D_P2M;
      3'b100:         digit = D_M2M;
      3'b101, 3'b110: digit = D_MM;
      default:        digit = D_ZERO;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/booth_r4_mult.sv
`default_nettype none
// ============================================================================
//  Module      : booth_r4_mult
//  Description : Parametrised radix-4 Booth sequential multiplier with
//                signed/unsigned modes, start/in_ready/done handshake and an
//                overflow flag for the truncated WIDTH-bit result.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_r4_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     mc,
  input  logic [WIDTH-1:0]     mp,
  output logic                 in_ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod,
  output logic [WIDTH-1:0]     result_lo,
  output logic [WIDTH-1:0]     result_hi,
  output logic                 ovf
);

  localparam int ITER  = booth_iter(WIDTH);
  localparam int CNT_W = $clog2(ITER + 1);
  localparam int AW    = WIDTH + 4;   // accumulator: room for +/-2M plus sign
  localparam int QW    = WIDTH + 2;   // operands extended so unsigned stays positive
  localparam int PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    a_q, a_d;
  logic [QW-1:0]    q_q, q_d;
  logic [QW-1:0]    m_q, m_d;
  logic             qm1_q, qm1_d;
  logic             sgn_q, sgn_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic             ovf_q, ovf_d;

  digit_t           digit;
  logic [AW-1:0]    m_ext;
  logic [AW-1:0]    addend;
  logic [AW-1:0]    a_sum;
  logic [AW-1:0]    a_shift;
  logic [QW-1:0]    q_shift;
  logic [PW-1:0]    prod_new;
  logic             ovf_new;
  logic [QW-1:0]    mc_ext;
  logic [QW-1:0]    mp_ext;

  booth_r4_enc u_enc (
    .win   ({q_q[1:0], qm1_q}),
    .digit (digit)
  );

  // One radix-4 step: add the recoded multiple, then shift {A,Q,q_m1} right by two
  always_comb begin
    m_ext  = {{2{m_q[QW-1]}}, m_q};
    addend = '0;
    case (digit)
      D_PM:    addend = m_ext;
      D_P2M:   addend = m_ext << 1;
      D_MM:    addend = -m_ext;
      D_M2M:   addend = -(m_ext << 1);
      default: addend = '0;
    endcase
    a_sum    = a_q + addend;
    a_shift  = {{2{a_sum[AW-1]}}, a_sum[AW-1:2]};
    q_shift  = {a_sum[1:0], q_q[QW-1:2]};
    prod_new = {a_shift[WIDTH-3:0], q_shift};
    if (sgn_q) begin
      ovf_new = !((&prod_new[PW-1:WIDTH-1]) || !(|prod_new[PW-1:WIDTH-1]));
    end else begin
      ovf_new = |prod_new[PW-1:WIDTH];
    end
  end

  // Operand extension at load: sign-extend in signed mode, zero-extend otherwise
  always_comb begin
    mc_ext = signed_mode ? {{2{mc[WIDTH-1]}}, mc} : {2'b00, mc};
    mp_ext = signed_mode ? {{2{mp[WIDTH-1]}}, mp} : {2'b00, mp};
  end

  // Controller: next state, datapath loads/updates and handshake outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    q_d      = q_q;
    m_d      = m_q;
    qm1_d    = qm1_q;
    sgn_d    = sgn_q;
    prod_d   = prod_q;
    ovf_d    = ovf_q;
    in_ready = (state_q == IDLE) || (state_q == DONE);
    busy     = (state_q == CALC);
    done     = (state_q == DONE);
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = CALC;
          m_d     = mc_ext;
          q_d     = mp_ext;
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          sgn_d   = signed_mode;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        a_d   = a_shift;
        q_d   = q_shift;
        qm1_d = q_q[1];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          prod_d  = prod_new;
          ovf_d   = ovf_new;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      sgn_q   <= 1'b0;
      prod_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      qm1_q   <= qm1_d;
      sgn_q   <= sgn_d;
      prod_q  <= prod_d;
      ovf_q   <= ovf_d;
    end
  end

  assign prod      = prod_q;
  assign result_lo = prod_q[WIDTH-1:0];
  assign result_hi = prod_q[PW-1:WIDTH];
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_r4_mult.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_r4_mult
//  Description : Scoreboard bench for booth_r4_mult at WIDTH=16 and WIDTH=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_r4_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start16, sgn16, in_ready16, busy16, done16, ovf16;
  logic [15:0] mc16, mp16, lo16, hi16;
  logic [31:0] prod16;

  logic        start8, sgn8, in_ready8, busy8, done8, ovf8;
  logic [7:0]  mc8, mp8, lo8, hi8;
  logic [15:0] prod8;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] p;
    bit          o;
    int          cyc;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];

  booth_r4_mult #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sgn16),
    .mc(mc16), .mp(mp16), .in_ready(in_ready16), .busy(busy16),
    .done(done16), .prod(prod16), .result_lo(lo16), .result_hi(hi16),
    .ovf(ovf16)
  );

  booth_r4_mult #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sgn8),
    .mc(mc8), .mp(mp8), .in_ready(in_ready8), .busy(busy8),
    .done(done8), .prod(prod8), .result_lo(lo8), .result_hi(hi8),
    .ovf(ovf8)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: integer multiply of the operands interpreted per mode
  function automatic void model(input int w, input bit s, input logic [15:0] a,
                                input logic [15:0] b, output logic [31:0] p,
                                output bit o);
    longint x, y, r;
    x = longint'(a);
    y = longint'(b);
    if (s && a[w-1]) x = x - (longint'(1) << w);
    if (s && b[w-1]) y = y - (longint'(1) << w);
    r = x * y;
    p = r[31:0];
    if (w == 8) p[31:16] = 16'h0;
    if (s) o = (r < -(longint'(1) << (w - 1))) || (r >= (longint'(1) << (w - 1)));
    else   o = (r >= (longint'(1) << w));
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h80;
      3:       return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic issue16(input bit s, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready16 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready16) begin
      checks++;
      errors++;
      $display("FAIL issue16_timeout: in_ready=%0b required 1", in_ready16);
    end
    start16 = 1'b1;
    sgn16   = s;
    mc16    = a;
    mp16    = b;
    model(16, s, a, b, e.p, e.o);
    @(negedge clk);
    e.cyc   = cyc;
    q16.push_back(e);
    start16 = 1'b0;
  endtask

  task automatic issue8(input bit s, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready8) begin
      checks++;
      errors++;
      $display("FAIL issue8_timeout: in_ready=%0b required 1", in_ready8);
    end
    start8 = 1'b1;
    sgn8   = s;
    mc8    = a;
    mp8    = b;
    model(8, s, {8'h0, a}, {8'h0, b}, e.p, e.o);
    @(negedge clk);
    e.cyc  = cyc;
    q8.push_back(e);
    start8 = 1'b0;
  endtask

  task automatic wait_idle16();
    int n;
    n = 0;
    while (q16.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q16.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain16_timeout: %0d results outstanding, required 0", q16.size());
      q16.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_idle8();
    int n;
    n = 0;
    while (q8.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain8_timeout: %0d results outstanding, required 0", q8.size());
      q8.delete();
    end
    @(negedge clk);
  endtask

  // Monitor for the 16-bit instance: pop and compare on every done pulse
  always @(negedge clk) begin
    exp_t e;
    if (done16) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done16_unexpected: done=1 prod=0x%0h, required no pulse", prod16);
      end else begin
        e = q16.pop_front();
        chk("prod16", 64'(prod16), 64'(e.p));
        chk("hilo16", 64'({hi16, lo16}), 64'(e.p));
        chk("ovf16", 64'(ovf16), 64'(e.o));
        chk("latency16", 64'(cyc - e.cyc), 64'd9);
      end
    end
  end

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done8_unexpected: done=1 prod=0x%0h, required no pulse", prod8);
      end else begin
        e = q8.pop_front();
        chk("prod8", 64'(prod8), 64'(e.p[15:0]));
        chk("hilo8", 64'({hi8, lo8}), 64'(e.p[15:0]));
        chk("ovf8", 64'(ovf8), 64'(e.o));
        chk("latency8", 64'(cyc - e.cyc), 64'd5);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b0;
    start16 = 1'b0; sgn16 = 1'b0; mc16 = '0; mp16 = '0;
    start8  = 1'b0; sgn8  = 1'b0; mc8  = '0; mp8  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_prod16", 64'(prod16), 64'h0);
    chk("rst_ovf16", 64'(ovf16), 64'h0);
    chk("rst_done16", 64'(done16), 64'h0);
    chk("rst_busy16", 64'(busy16), 64'h0);
    chk("rst_in_ready16", 64'(in_ready16), 64'h1);
    chk("rst_prod8", 64'(prod8), 64'h0);

    // Signed 3 x -5
    issue16(1'b1, 16'd3, 16'hFFFB);
    chk("t1_busy", 64'(busy16), 64'h1);
    chk("t1_in_ready", 64'(in_ready16), 64'h0);
    wait_idle16();
    chk("t1_prod", 64'(prod16), 64'hFFFF_FFF1);
    chk("t1_lo", 64'(lo16), 64'hFFF1);
    chk("t1_ovf", 64'(ovf16), 64'h0);

    // Most-negative squared, unsigned max squared, zero operand
    issue16(1'b1, 16'h8000, 16'h8000);
    wait_idle16();
    chk("t2_prod_minmin", 64'(prod16), 64'h4000_0000);
    chk("t2_hi_minmin", 64'(hi16), 64'h4000);
    chk("t2_ovf_minmin", 64'(ovf16), 64'h1);
    issue16(1'b0, 16'hFFFF, 16'hFFFF);
    wait_idle16();
    chk("t2_prod_maxmax", 64'(prod16), 64'hFFFE_0001);
    chk("t2_ovf_maxmax", 64'(ovf16), 64'h1);
    issue16(1'b1, 16'h0000, 16'h1234);
    wait_idle16();
    chk("t2_prod_zero", 64'(prod16), 64'h0);
    chk("t2_ovf_zero", 64'(ovf16), 64'h0);

    // start held high while busy with different operands
    issue16(1'b1, 16'd100, 16'hFFF9);
    start16 = 1'b1; sgn16 = 1'b0; mc16 = 16'd55; mp16 = 16'd77;
    repeat (4) @(negedge clk);
    start16 = 1'b0;
    wait_idle16();
    repeat (12) @(negedge clk);
    chk("t3_prod", 64'(prod16), 64'hFFFF_FD44);

    // Back-to-back: accept in the DONE cycle, old result held meanwhile
    issue16(1'b1, 16'd1234, 16'hFFFD);
    n = 0;
    while (!done16 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_done_seen", 64'(done16), 64'h1);
    issue16(1'b0, 16'd200, 16'd300);
    chk("t5_b2b_busy", 64'(busy16), 64'h1);
    chk("t5_hold_a", 64'(prod16), 64'hFFFF_F18A);
    repeat (5) @(negedge clk);
    chk("t5_hold_b", 64'(prod16), 64'hFFFF_F18A);
    wait_idle16();
    chk("t5_prod", 64'(prod16), 64'd60000);
    chk("t5_ovf", 64'(ovf16), 64'h0);

    // Reset in the middle of an operation
    issue16(1'b1, 16'h1234, 16'h0F0F);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t4_prod", 64'(prod16), 64'h0);
    chk("t4_busy", 64'(busy16), 64'h0);
    chk("t4_done", 64'(done16), 64'h0);
    chk("t4_in_ready", 64'(in_ready16), 64'h1);
    chk("t4_ovf", 64'(ovf16), 64'h0);
    rst = 1'b1;
    void'(q16.pop_back());
    repeat (15) @(negedge clk);
    chk("t4_prod_after", 64'(prod16), 64'h0);

    // Random sweep on both widths in parallel
    fork
      for (int i = 0; i < 5000; i++) issue16(1'($urandom_range(0, 1)), pick16(), pick16());
      for (int j = 0; j < 5000; j++) issue8(1'($urandom_range(0, 1)), pick8(), pick8());
    join
    wait_idle16();
    wait_idle8();
    repeat (12) @(negedge clk);
    chk("q16_drained", 64'(q16.size()), 64'h0);
    chk("q8_drained", 64'(q8.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/booth_r4_mult.md
Name: booth_r4_mult

Overview:
Parametrised radix-4 Booth sequential multiplier. It is the next generation of the team's 16-bit radix-2 Booth unit and differs from it in four ways:
- Generic operand width.
- Signed and unsigned operating modes.
- Adder/subtractor held internally.
- start/in_ready/done handshake, with an overflow flag for the truncated W-bit result.

It sits in the arithmetic datapath beside the ALU and is shared by the result_lo/residue consumers.

Parameters:
WIDTH, 16, operand width W. Must be even and >= 4.
ITER, WIDTH/2+1, number of radix-4 iterations (derived, not overridable).

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-low reset
start  input  1  request. Accepted only when in_ready=1.
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned. Sampled with start.
mc  input  WIDTH  multiplicand. Sampled with start.
mp  input  WIDTH  multiplier. Sampled with start.
in_ready  output  1  block can accept start this cycle
busy  output  1  iteration in progress
done  output  1  one-cycle pulse when prod becomes valid
prod  output  2*WIDTH  full product
result_lo  output  WIDTH  prod[W-1:0]
result_hi  output  WIDTH  prod[2W-1:W]
ovf  output  1  result_lo does not represent the full product in the active mode

Behaviour:
- Reset: rst=0 sampled at posedge forces the following, overriding any in-flight operation:
  - state=IDLE
  - prod=0, ovf=0, done=0, busy=0
  - iteration counter=0
  - in_ready=1 once rst is released.
- States: IDLE, CALC, DONE.
  - IDLE --start--> CALC
  - CALC --(cnt==ITER-1)--> DONE
  - DONE --start--> CALC
  - DONE --no start--> IDLE
- in_ready = (state==IDLE || state==DONE). start is ignored in CALC, with no effect on the operation or the outputs.
- Load at accept edge E0:
  - M = mc extended to W+2 bits (sign-extended if signed_mode, else zero-extended).
  - Q = mp extended to W+2 bits by the same rule.
  - A = 0, with width W+4.
  - q_m1 = 0, cnt = 0.
  - The mode is latched for the whole operation.
- Each CALC edge:
  - Recode d = booth digit of {Q[1:0], q_m1}:
    - 000, 111 -> 0
    - 001, 010 -> +M
    - 011 -> +2M
    - 100 -> -2M
    - 101, 110 -> -M
  - A_next = A + d*M, with M sign-extended to W+4 bits.
  - {A, Q, q_m1} = arithmetic right shift by 2 of {A_next, Q, q_m1}.
  - cnt++.
- Completion:
  - After ITER iterations, prod = lower 2W bits of {A, Q}. This is registered at edge E0+ITER, when the state enters DONE.
  - done=1 for exactly the cycle following that edge.
  - busy=1 from E0+1 through E0+ITER, i.e. in the cycles when state==CALC.
  - Latency for W=16: start edge to done high is 9 cycles.
- Output holding: prod, result_lo, result_hi and ovf hold their values until the next completion. They do not change at a new accept.
- ovf rules:
  - signed: ovf=1 iff prod[2W-1:W-1] are not all equal.
  - unsigned: ovf=1 iff prod[2W-1:W] != 0.
- Back-to-back operation: start during the DONE cycle is accepted. done still pulses for that cycle, and the next operation begins with no idle cycle.
- Boundary cases:
  - Most-negative × most-negative in signed mode gives the exact product (headroom is W+4).
  - Unsigned max × max gives the exact product.
  - Zero operands give prod=0, ovf=0.

Decomposition:
- Package booth_pkg:
  - typedef enum state_t {IDLE, CALC, DONE}
  - typedef enum digit_t {D_ZERO, D_PM, D_P2M, D_MM, D_M2M}
  - function for ITER from WIDTH.
- Sub-module booth_r4_enc: purely combinational. Input is the 3-bit window; output is digit_t. It is instantiated once in booth_r4_mult, which owns the FSM, the registers, and the add/shift datapath.

Test Plan:
1. W=16, signed, mc=3, mp=-5 (0xFFFB) -> done 9 cycles after start edge, prod=0xFFFFFFF1, result_lo=0xFFF1, ovf=0.
2. W=16, signed, mc=mp=0x8000 -> prod=0x40000000, result_hi=0x4000, ovf=1. Unsigned mc=mp=0xFFFF -> prod=0xFFFE0001, ovf=1.
3. Start held high while busy: the second operand set presented mid-CALC is ignored. prod equals the first operation's product, and exactly one done pulse occurs.
4. rst=0 asserted at iteration 4 -> next cycle prod=0, busy=0, done=0, in_ready=1. No done pulse follows.
5. Back-to-back: start asserted in the DONE cycle with new operands (unsigned 200×300) -> the first result is held until 9 cycles later, then prod=60000 and ovf=0.
6. Random sweep at WIDTH=8 and WIDTH=16, both modes, 10k operand pairs -> prod matches the reference model (signed/unsigned multiply) and ovf matches the rule above.
